// File: rtl/icache_refill_ctrl.sv
// rtl/icache_refill_ctrl.sv - miss-refill engine for the 8-entry fully-associative icache group
module icache_refill_ctrl #(
    parameter int PC_W   = 32,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss1_i,
    input  logic [PC_W-1:0]   pc1_i,
    input  logic              miss2_i,
    input  logic [PC_W-1:0]   pc2_i,
    input  logic              flush_i,
    output logic              arvalid_o,
    output logic [PC_W-1:0]   araddr_o,
    input  logic              arready_i,
    input  logic              rvalid_i,
    input  logic [INST_W-1:0] rdata_i,
    input  logic [1:0]        rresp_i,
    output logic              rready_o,
    output logic              we_o,
    output logic [2:0]        waddr_o,
    output logic [PC_W-1:0]   wpc_o,
    output logic [INST_W-1:0] winst_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_WR} state_t;

    state_t              state_q;
    logic [2:0]          ptr_q;
    logic [PC_W-1:0]     pc2_q;
    logic [PC_W-1:0]     cur_pc_q;
    logic                need2_q;
    logic                cancel_q;
    logic                arvalid_q;
    logic [PC_W-1:0]     araddr_q;
    logic                rready_q;
    logic                we_q;
    logic [2:0]          waddr_q;
    logic [PC_W-1:0]     wpc_q;
    logic [INST_W-1:0]   winst_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= 3'd0;
            pc2_q     <= '0;
            cur_pc_q  <= '0;
            need2_q   <= 1'b0;
            cancel_q  <= 1'b0;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            rready_q  <= 1'b0;
            we_q      <= 1'b0;
            waddr_q   <= 3'd0;
            wpc_q     <= '0;
            winst_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cancel_q <= 1'b0;
                    if (!flush_i && (miss1_i || miss2_i)) begin
                        // need2_q only tracks a second, distinct refill queued behind pc1
                        need2_q   <= miss1_i && miss2_i && (pc2_i != pc1_i);
                        pc2_q     <= pc2_i;
                        cur_pc_q  <= miss1_i ? pc1_i : pc2_i;
                        araddr_q  <= miss1_i ? pc1_i : pc2_i;
                        arvalid_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= S_AR;
                    end
                end
                S_AR: begin
                    if (flush_i) begin
                        cancel_q <= 1'b1;
                    end
                    if (arready_i) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_R;
                    end
                end
                S_R: begin
                    if (rvalid_i) begin
                        rready_q <= 1'b0;
                        if (cancel_q || flush_i) begin
                            need2_q  <= 1'b0;
                            cancel_q <= 1'b0;
                            busy_q   <= 1'b0;
                            state_q  <= S_IDLE;
                        end else if (rresp_i != 2'd0) begin
                            err_q   <= 1'b1;
                            need2_q <= 1'b0;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            we_q    <= 1'b1;
                            waddr_q <= ptr_q;
                            wpc_q   <= cur_pc_q;
                            winst_q <= rdata_i;
                            done_q  <= !need2_q;
                            state_q <= S_WR;
                        end
                    end else if (flush_i) begin
                        cancel_q <= 1'b1;
                    end
                end
                S_WR: begin
                    ptr_q <= ptr_q + 3'd1;
                    if (need2_q) begin
                        need2_q   <= 1'b0;
                        cur_pc_q  <= pc2_q;
                        araddr_q  <= pc2_q;
                        arvalid_q <= 1'b1;
                        state_q   <= S_AR;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign arvalid_o = arvalid_q;
    assign araddr_o  = araddr_q;
    assign rready_o  = rready_q;
    assign we_o      = we_q;
    assign waddr_o   = waddr_q;
    assign wpc_o     = wpc_q;
    assign winst_o   = winst_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb/tb_icache_refill_ctrl.sv - directed self-checking bench for icache_refill_ctrl
module tb_icache_refill_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        miss1_i, miss2_i, flush_i;
    logic [31:0] pc1_i, pc2_i;
    logic        arvalid_o, arready_i, rvalid_i, rready_o;
    logic [31:0] araddr_o, rdata_i;
    logic [1:0]  rresp_i;
    logic        we_o, busy_o, done_o, err_o;
    logic [2:0]  waddr_o;
    logic [31:0] wpc_o, winst_o;

    int n_chk  = 0;
    int n_pass = 0;

    icache_refill_ctrl #(.PC_W(32), .INST_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .miss1_i(miss1_i), .pc1_i(pc1_i), .miss2_i(miss2_i), .pc2_i(pc2_i),
        .flush_i(flush_i),
        .arvalid_o(arvalid_o), .araddr_o(araddr_o), .arready_i(arready_i),
        .rvalid_i(rvalid_i), .rdata_i(rdata_i), .rresp_i(rresp_i), .rready_o(rready_o),
        .we_o(we_o), .waddr_o(waddr_o), .wpc_o(wpc_o), .winst_o(winst_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        miss1_i = 0; miss2_i = 0; flush_i = 0; pc1_i = 0; pc2_i = 0;
        arready_i = 1; rvalid_i = 0; rdata_i = 0; rresp_i = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++; if ({arvalid_o, rready_o, we_o, busy_o, done_o, err_o} !== 6'b0) $display("FAIL reset_ctrl: got %b want 000000", {arvalid_o, rready_o, we_o, busy_o, done_o, err_o}); else n_pass++;
        n_chk++; if ({araddr_o, wpc_o, winst_o, waddr_o} !== 99'd0) $display("FAIL reset_data: got %h want 0", {araddr_o, wpc_o, winst_o, waddr_o}); else n_pass++;
        miss1_i = 1; pc1_i = 32'h0000_0040;
        tick();
        miss1_i = 0;
        n_chk++; if (arvalid_o !== 1'b1) $display("FAIL reset_pre_ar: got %b want 1", arvalid_o); else n_pass++;
        rst_n = 0;
        tick();
        rst_n = 1;
        n_chk++; if ({arvalid_o, busy_o, we_o} !== 3'b0) $display("FAIL reset_abort: got %b want 000", {arvalid_o, busy_o, we_o}); else n_pass++;
        tick(); tick(); tick();
        n_chk++; if ({arvalid_o, we_o, busy_o} !== 3'b0) $display("FAIL reset_abort_quiet: got %b want 000", {arvalid_o, we_o, busy_o}); else n_pass++;
    endtask

    task automatic test_single_miss();
        do_reset();
        miss1_i = 1; pc1_i = 32'h1C00_0000;
        tick();
        miss1_i = 0;
        n_chk++; if ({arvalid_o, busy_o} !== 2'b11 || araddr_o !== 32'h1C00_0000) $display("FAIL single_c1: got arv/busy=%b addr=%h want 11 1c000000", {arvalid_o, busy_o}, araddr_o); else n_pass++;
        tick();
        rvalid_i = 1; rdata_i = 32'h0280_0C0C;
        n_chk++; if ({rready_o, arvalid_o} !== 2'b10) $display("FAIL single_c2: got rready/arv=%b want 10", {rready_o, arvalid_o}); else n_pass++;
        tick();
        rvalid_i = 0;
        n_chk++; if (we_o !== 1'b1 || waddr_o !== 3'd0 || wpc_o !== 32'h1C00_0000 || winst_o !== 32'h0280_0C0C || done_o !== 1'b1) $display("FAIL single_c3: got we=%b wa=%0d wpc=%h winst=%h done=%b want 1 0 1c000000 02800c0c 1", we_o, waddr_o, wpc_o, winst_o, done_o); else n_pass++;
        tick();
        n_chk++; if ({busy_o, we_o, done_o, rready_o} !== 4'b0) $display("FAIL single_c4: got busy/we/done/rready=%b want 0000", {busy_o, we_o, done_o, rready_o}); else n_pass++;
        n_chk++; if (wpc_o !== 32'h1C00_0000 || winst_o !== 32'h0280_0C0C) $display("FAIL single_hold: got wpc=%h winst=%h want 1c000000 02800c0c", wpc_o, winst_o); else n_pass++;
    endtask

    task automatic test_dual_distinct();
        do_reset();
        miss1_i = 1; pc1_i = 32'h100; miss2_i = 1; pc2_i = 32'h104;
        tick();
        idle_inputs();
        n_chk++; if (arvalid_o !== 1'b1 || araddr_o !== 32'h100) $display("FAIL dual_ar1: got arv=%b addr=%h want 1 100", arvalid_o, araddr_o); else n_pass++;
        tick();
        rvalid_i = 1; rdata_i = 32'hAAAA_0001;
        tick();
        rvalid_i = 0;
        n_chk++; if (we_o !== 1'b1 || waddr_o !== 3'd0 || wpc_o !== 32'h100 || winst_o !== 32'hAAAA_0001 || done_o !== 1'b0) $display("FAIL dual_wr1: got we=%b wa=%0d wpc=%h winst=%h done=%b want 1 0 100 aaaa0001 0", we_o, waddr_o, wpc_o, winst_o, done_o); else n_pass++;
        tick();
        n_chk++; if (arvalid_o !== 1'b1 || araddr_o !== 32'h104 || busy_o !== 1'b1) $display("FAIL dual_ar2: got arv=%b addr=%h busy=%b want 1 104 1", arvalid_o, araddr_o, busy_o); else n_pass++;
        tick();
        rvalid_i = 1; rdata_i = 32'hBBBB_0002;
        tick();
        rvalid_i = 0;
        n_chk++; if (we_o !== 1'b1 || waddr_o !== 3'd1 || wpc_o !== 32'h104 || winst_o !== 32'hBBBB_0002 || done_o !== 1'b1) $display("FAIL dual_wr2: got we=%b wa=%0d wpc=%h winst=%h done=%b want 1 1 104 bbbb0002 1", we_o, waddr_o, wpc_o, winst_o, done_o); else n_pass++;
        tick();
        n_chk++; if ({busy_o, done_o, arvalid_o} !== 3'b0) $display("FAIL dual_end: got busy/done/arv=%b want 000", {busy_o, done_o, arvalid_o}); else n_pass++;
    endtask

    task automatic test_dual_same();
        int ar_cnt;
        int we_cnt;
        do_reset();
        ar_cnt = 0; we_cnt = 0;
        miss1_i = 1; pc1_i = 32'h200; miss2_i = 1; pc2_i = 32'h200;
        tick();
        idle_inputs();
        rvalid_i = 1; rdata_i = 32'h1234_5678;
        for (int i = 1; i <= 10; i++) begin
            if (arvalid_o && arready_i) ar_cnt++;
            if (we_o) begin
                we_cnt++;
                n_chk++; if (i !== 3 || waddr_o !== 3'd0 || wpc_o !== 32'h200 || done_o !== 1'b1) $display("FAIL same_wr: got cyc=%0d wa=%0d wpc=%h done=%b want 3 0 200 1", i, waddr_o, wpc_o, done_o); else n_pass++;
            end
            tick();
        end
        n_chk++; if (ar_cnt !== 1 || we_cnt !== 1) $display("FAIL same_counts: got ar=%0d we=%0d want 1 1", ar_cnt, we_cnt); else n_pass++;
    endtask

    task automatic test_backpressure();
        int we_cnt;
        int unstable;
        do_reset();
        we_cnt = 0; unstable = 0;
        miss1_i = 1; pc1_i = 32'h300;
        arready_i = 0;
        tick();
        miss1_i = 0;
        for (int c = 1; c <= 12; c++) begin
            arready_i = (c == 4);
            rvalid_i  = (c == 9);
            rdata_i   = (c == 9) ? 32'hCAFE_0300 : 32'hDEAD_DEAD;
            if (c <= 4 && (arvalid_o !== 1'b1 || araddr_o !== 32'h300)) unstable++;
            if (c >= 5 && arvalid_o) unstable++;
            if (we_o) begin
                we_cnt++;
                n_chk++; if (c !== 10 || winst_o !== 32'hCAFE_0300 || wpc_o !== 32'h300) $display("FAIL bp_wr: got cyc=%0d winst=%h wpc=%h want 10 cafe0300 300", c, winst_o, wpc_o); else n_pass++;
            end
            tick();
        end
        idle_inputs();
        n_chk++; if (unstable !== 0) $display("FAIL bp_ar_stable: got %0d bad cycles want 0", unstable); else n_pass++;
        n_chk++; if (we_cnt !== 1) $display("FAIL bp_we_count: got %0d want 1", we_cnt); else n_pass++;
    endtask

    task automatic test_wrap();
        int bad;
        do_reset();
        bad = 0;
        for (int i = 0; i < 9; i++) begin
            miss1_i = 1; pc1_i = 32'h1000 + 32'(i * 4);
            tick();
            miss1_i = 0;
            tick();
            rvalid_i = 1; rdata_i = 32'h5000 + 32'(i);
            tick();
            rvalid_i = 0;
            if (we_o !== 1'b1 || waddr_o !== 3'(i % 8) || wpc_o !== 32'h1000 + 32'(i * 4)) begin
                bad++;
                $display("FAIL wrap_waddr: iter %0d got we=%b wa=%0d want 1 %0d", i, we_o, waddr_o, i % 8);
            end
            tick();
        end
        n_chk++; if (bad !== 0) $display("FAIL wrap_total: got %0d bad writes want 0", bad); else n_pass++;
        n_chk++; if (waddr_o !== 3'd0) $display("FAIL wrap_last: got %0d want 0", waddr_o); else n_pass++;
    endtask

    task automatic test_flush();
        int stray;
        do_reset();
        stray = 0;
        miss1_i = 1; pc1_i = 32'h400; miss2_i = 1; pc2_i = 32'h404; flush_i = 1;
        tick();
        idle_inputs();
        n_chk++; if ({arvalid_o, busy_o} !== 2'b00) $display("FAIL flush_idle_wins: got arv/busy=%b want 00", {arvalid_o, busy_o}); else n_pass++;
        miss1_i = 1; pc1_i = 32'h400; miss2_i = 1; pc2_i = 32'h404;
        tick();
        idle_inputs();
        tick();
        flush_i = 1;
        tick();
        flush_i = 0;
        n_chk++; if (rready_o !== 1'b1 || busy_o !== 1'b1) $display("FAIL flush_in_r: got rready/busy=%b%b want 11", rready_o, busy_o); else n_pass++;
        rvalid_i = 1; rdata_i = 32'hBAD0_0400;
        tick();
        rvalid_i = 0;
        n_chk++; if ({busy_o, we_o, done_o} !== 3'b0) $display("FAIL flush_after_r: got busy/we/done=%b want 000", {busy_o, we_o, done_o}); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            if (arvalid_o || we_o || busy_o) stray++;
            tick();
        end
        n_chk++; if (stray !== 0) $display("FAIL flush_no_pc2: got %0d active cycles want 0", stray); else n_pass++;
    endtask

    task automatic test_error();
        int stray;
        do_reset();
        stray = 0;
        miss1_i = 1; pc1_i = 32'h500; miss2_i = 1; pc2_i = 32'h504;
        tick();
        idle_inputs();
        tick();
        rvalid_i = 1; rresp_i = 2'd2; rdata_i = 32'hEEEE_EEEE;
        tick();
        idle_inputs();
        n_chk++; if ({err_o, we_o, busy_o, done_o} !== 4'b1000) $display("FAIL err_pulse: got err/we/busy/done=%b want 1000", {err_o, we_o, busy_o, done_o}); else n_pass++;
        tick();
        n_chk++; if (err_o !== 1'b0) $display("FAIL err_one_cycle: got %b want 0", err_o); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            if (arvalid_o || we_o) stray++;
            tick();
        end
        n_chk++; if (stray !== 0) $display("FAIL err_no_pc2: got %0d active cycles want 0", stray); else n_pass++;
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        test_reset();
        test_single_miss();
        test_dual_distinct();
        test_dual_same();
        test_backpressure();
        test_wrap();
        test_flush();
        test_error();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
- Miss-refill engine that writes the 8-entry fully-associative instruction cache group; it owns the group's write port (we/waddr/wpc/winst).
- Takes up to two fetch misses per cycle from the dual-issue fetch stage and fetches each missing instruction over a single-beat AXI-style read channel.
- Writes each returned instruction into a round-robin victim entry and stalls fetch via busy_o until refill completes.

Parameters:
- PC_W, 32, PC/tag and read-address width
- INST_W, 32, instruction width
- Entry count fixed at 8 (3-bit victim pointer); not a parameter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- miss1_i  in  1  fetch port 1 read enabled and missed
- pc1_i  in  PC_W  port 1 PC
- miss2_i  in  1  fetch port 2 read enabled and missed
- pc2_i  in  PC_W  port 2 PC
- flush_i  in  1  cancel pending refill (branch/exception redirect)
- arvalid_o  out  1  read address valid
- araddr_o  out  PC_W  read address (= PC being refilled)
- arready_i  in  1  read address accepted
- rvalid_i  in  1  read data valid
- rdata_i  in  INST_W  read data
- rresp_i  in  2  response, 0 = OKAY
- rready_o  out  1  read data ready
- we_o  out  1  cache group write enable
- waddr_o  out  3  cache group entry index
- wpc_o  out  PC_W  tag written
- winst_o  out  INST_W  instruction written
- busy_o  out  1  refill in progress; fetch stalls
- done_o  out  1  one-cycle pulse: all requested refills written
- err_o  out  1  one-cycle pulse: non-OKAY response

Behaviour:
- All outputs registered. Reset (rst_n=0 at posedge): state IDLE, victim ptr=0, all outputs 0. Reset mid-transaction aborts immediately; no write issued.
- States: IDLE, AR, R, WR.
- IDLE: if flush_i=1, nothing captured (flush wins over a same-cycle miss). Else if miss1_i|miss2_i: latch pc1/pc2; need1=miss1_i; need2=miss2_i & !(miss1_i & pc2_i==pc1_i). Go to AR, current PC = pc1 if need1 else pc2. busy_o=1 from the next cycle.
- AR: arvalid_o=1, araddr_o=current PC, both held stable until arready_i=1. On handshake go to R. arvalid_o is never dropped before handshake, even on flush.
- R: rready_o=1. On rvalid_i=1, capture rdata_i and rresp_i.
  - If cancel flag set: IDLE, no write, busy_o=0 next cycle.
  - Else if rresp_i!=0: err_o=1 one cycle, remaining need cleared, IDLE, no write.
  - Else: WR.
- WR (exactly 1 cycle): we_o=1, waddr_o=ptr, wpc_o=current PC, winst_o=captured data; ptr<=ptr+1 mod 8 (7 wraps to 0).
  - If the second need is still pending: AR with pc2.
  - Else: done_o=1 in this same cycle; IDLE.
- flush_i in AR or R sets the cancel flag. The outstanding AR/R transaction completes; nothing is written; the second need is dropped. The flag clears on return to IDLE.
- wpc_o/winst_o hold the last written values when we_o=0, because the group forwards them.
- busy_o=1 in AR, R and WR. Miss inputs are ignored when not IDLE.
- Zero-wait latency (arready=1, rvalid the cycle after AR):
  - miss at cycle 0; AR at c1; R at c2; we_o at c3; IDLE at c4.
  - Dual distinct miss: second we_o at c6, done_o at c6.
- At most one outstanding read; rready_o=0 outside R.

Test Plan:
- Single miss: miss1_i=1, pc1=0x1C000000, zero-wait memory, rdata=0x02800C0C -> araddr=0x1C000000 at c1; we_o=1 at c3 with waddr=0, wpc=0x1C000000, winst=0x02800C0C; done_o at c3; busy_o low at c4.
- Dual miss distinct: pc1=0x100, pc2=0x104 -> two AR transactions in order 0x100 then 0x104; writes to waddr 0 then 1; single done_o on the second write.
- Dual miss same PC: pc1=pc2=0x200 -> exactly one AR and one write.
- Backpressure: arready_i low 3 cycles, rvalid_i delayed 4 cycles -> arvalid_o/araddr_o stable throughout; exactly one we_o after the data beat.
- Wrap: 9 sequential single misses -> waddr sequence 0..7, then 0.
- Flush in R with pending pc2 -> no we_o, no second AR, busy_o=0 the cycle after rvalid_i.
- Error: rresp_i=2 on pc1 with need2 set -> err_o pulse, no we_o, no AR for pc2.
